// File: rtl/sha2_core.sv
// SHA-2 compression engine: SHA-224/256 (WordSize 32) or SHA-384/512 (WordSize 64),
// one round per cycle, chaining hash state across pre-padded blocks of a message.
module sha2_core #(
   parameter int unsigned WordSize    = 32,
   parameter int unsigned BlockWidth  = 16 * WordSize,
   parameter int unsigned DigestWidth = 8 * WordSize
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [BlockWidth-1:0]  block_i,
   input  logic                   block_valid_i,
   output logic                   block_ready_o,
   input  logic                   last_i,
   input  logic                   mode_i,
   input  logic                   abort_i,
   output logic                   busy_o,
   output logic [DigestWidth-1:0] digest_o,
   output logic                   digest_valid_o
);

   if (WordSize != 32 && WordSize != 64) begin : g_bad_word_size
      $error("sha2_core: WordSize must be 32 or 64");
   end
   if (BlockWidth != 16 * WordSize || DigestWidth != 8 * WordSize) begin : g_bad_derived
      $error("sha2_core: BlockWidth and DigestWidth are derived from WordSize");
   end

   localparam int unsigned NumRounds = (WordSize == 64) ? 80 : 64;
   localparam int unsigned TruncBits = (WordSize == 64) ? 128 : 32;
   localparam logic [DigestWidth-1:0] TruncMask =
      {{(DigestWidth - TruncBits){1'b1}}, {TruncBits{1'b0}}};

   localparam int unsigned BS0_A = (WordSize == 64) ? 28 : 2;
   localparam int unsigned BS0_B = (WordSize == 64) ? 34 : 13;
   localparam int unsigned BS0_C = (WordSize == 64) ? 39 : 22;
   localparam int unsigned BS1_A = (WordSize == 64) ? 14 : 6;
   localparam int unsigned BS1_B = (WordSize == 64) ? 18 : 11;
   localparam int unsigned BS1_C = (WordSize == 64) ? 41 : 25;
   localparam int unsigned SS0_A = (WordSize == 64) ? 1  : 7;
   localparam int unsigned SS0_B = (WordSize == 64) ? 8  : 18;
   localparam int unsigned SS0_S = (WordSize == 64) ? 7  : 3;
   localparam int unsigned SS1_A = (WordSize == 64) ? 19 : 17;
   localparam int unsigned SS1_B = (WordSize == 64) ? 61 : 19;
   localparam int unsigned SS1_S = (WordSize == 64) ? 6  : 10;

   typedef logic [WordSize-1:0] word_t;
   typedef enum logic [2:0] {ST_IDLE, ST_HASH, ST_FINAL, ST_WAIT, ST_DONE} state_e;

   function automatic word_t rotr(input word_t x, input int unsigned n);
      return (x >> n) | (x << (WordSize - n));
   endfunction

   function automatic word_t big_sigma0(input word_t x);
      return rotr(x, BS0_A) ^ rotr(x, BS0_B) ^ rotr(x, BS0_C);
   endfunction

   function automatic word_t big_sigma1(input word_t x);
      return rotr(x, BS1_A) ^ rotr(x, BS1_B) ^ rotr(x, BS1_C);
   endfunction

   function automatic word_t small_sigma0(input word_t x);
      return rotr(x, SS0_A) ^ rotr(x, SS0_B) ^ (x >> SS0_S);
   endfunction

   function automatic word_t small_sigma1(input word_t x);
      return rotr(x, SS1_A) ^ rotr(x, SS1_B) ^ (x >> SS1_S);
   endfunction

   // The 32-bit K and IV words are the upper halves of the 64-bit constants, and the
   // SHA-224 IV is the lower half of the SHA-384 IV, so only 64-bit tables are kept.
   function automatic word_t k_word(input logic [6:0] idx);
      logic [63:0] k;
      case (idx)
         7'd0:  k = 64'h428a2f98d728ae22;  7'd1:  k = 64'h7137449123ef65cd;
         7'd2:  k = 64'hb5c0fbcfec4d3b2f;  7'd3:  k = 64'he9b5dba58189dbbc;
         7'd4:  k = 64'h3956c25bf348b538;  7'd5:  k = 64'h59f111f1b605d019;
         7'd6:  k = 64'h923f82a4af194f9b;  7'd7:  k = 64'hab1c5ed5da6d8118;
         7'd8:  k = 64'hd807aa98a3030242;  7'd9:  k = 64'h12835b0145706fbe;
         7'd10: k = 64'h243185be4ee4b28c;  7'd11: k = 64'h550c7dc3d5ffb4e2;
         7'd12: k = 64'h72be5d74f27b896f;  7'd13: k = 64'h80deb1fe3b1696b1;
         7'd14: k = 64'h9bdc06a725c71235;  7'd15: k = 64'hc19bf174cf692694;
         7'd16: k = 64'he49b69c19ef14ad2;  7'd17: k = 64'hefbe4786384f25e3;
         7'd18: k = 64'h0fc19dc68b8cd5b5;  7'd19: k = 64'h240ca1cc77ac9c65;
         7'd20: k = 64'h2de92c6f592b0275;  7'd21: k = 64'h4a7484aa6ea6e483;
         7'd22: k = 64'h5cb0a9dcbd41fbd4;  7'd23: k = 64'h76f988da831153b5;
         7'd24: k = 64'h983e5152ee66dfab;  7'd25: k = 64'ha831c66d2db43210;
         7'd26: k = 64'hb00327c898fb213f;  7'd27: k = 64'hbf597fc7beef0ee4;
         7'd28: k = 64'hc6e00bf33da88fc2;  7'd29: k = 64'hd5a79147930aa725;
         7'd30: k = 64'h06ca6351e003826f;  7'd31: k = 64'h142929670a0e6e70;
         7'd32: k = 64'h27b70a8546d22ffc;  7'd33: k = 64'h2e1b21385c26c926;
         7'd34: k = 64'h4d2c6dfc5ac42aed;  7'd35: k = 64'h53380d139d95b3df;
         7'd36: k = 64'h650a73548baf63de;  7'd37: k = 64'h766a0abb3c77b2a8;
         7'd38: k = 64'h81c2c92e47edaee6;  7'd39: k = 64'h92722c851482353b;
         7'd40: k = 64'ha2bfe8a14cf10364;  7'd41: k = 64'ha81a664bbc423001;
         7'd42: k = 64'hc24b8b70d0f89791;  7'd43: k = 64'hc76c51a30654be30;
         7'd44: k = 64'hd192e819d6ef5218;  7'd45: k = 64'hd69906245565a910;
         7'd46: k = 64'hf40e35855771202a;  7'd47: k = 64'h106aa07032bbd1b8;
         7'd48: k = 64'h19a4c116b8d2d0c8;  7'd49: k = 64'h1e376c085141ab53;
         7'd50: k = 64'h2748774cdf8eeb99;  7'd51: k = 64'h34b0bcb5e19b48a8;
         7'd52: k = 64'h391c0cb3c5c95a63;  7'd53: k = 64'h4ed8aa4ae3418acb;
         7'd54: k = 64'h5b9cca4f7763e373;  7'd55: k = 64'h682e6ff3d6b2b8a3;
         7'd56: k = 64'h748f82ee5defb2fc;  7'd57: k = 64'h78a5636f43172f60;
         7'd58: k = 64'h84c87814a1f0ab72;  7'd59: k = 64'h8cc702081a6439ec;
         7'd60: k = 64'h90befffa23631e28;  7'd61: k = 64'ha4506cebde82bde9;
         7'd62: k = 64'hbef9a3f7b2c67915;  7'd63: k = 64'hc67178f2e372532b;
         7'd64: k = 64'hca273eceea26619c;  7'd65: k = 64'hd186b8c721c0c207;
         7'd66: k = 64'heada7dd6cde0eb1e;  7'd67: k = 64'hf57d4f7fee6ed178;
         7'd68: k = 64'h06f067aa72176fba;  7'd69: k = 64'h0a637dc5a2c898a6;
         7'd70: k = 64'h113f9804bef90dae;  7'd71: k = 64'h1b710b35131c471b;
         7'd72: k = 64'h28db77f523047d84;  7'd73: k = 64'h32caab7b40c72493;
         7'd74: k = 64'h3c9ebe0a15c9bebc;  7'd75: k = 64'h431d67c49c100d4c;
         7'd76: k = 64'h4cc5d4becb3e42b6;  7'd77: k = 64'h597f299cfc657e2a;
         7'd78: k = 64'h5fcb6fab3ad6faec;  7'd79: k = 64'h6c44198c4a475817;
         default: k = 64'h0;
      endcase
      return k[63 -: WordSize];
   endfunction

   function automatic word_t iv_word(input logic [2:0] idx, input logic trunc);
      logic [63:0] v512;
      logic [63:0] v384;
      case (idx)
         3'd0: begin v512 = 64'h6a09e667f3bcc908; v384 = 64'hcbbb9d5dc1059ed8; end
         3'd1: begin v512 = 64'hbb67ae8584caa73b; v384 = 64'h629a292a367cd507; end
         3'd2: begin v512 = 64'h3c6ef372fe94f82b; v384 = 64'h9159015a3070dd17; end
         3'd3: begin v512 = 64'ha54ff53a5f1d36f1; v384 = 64'h152fecd8f70e5939; end
         3'd4: begin v512 = 64'h510e527fade682d1; v384 = 64'h67332667ffc00b31; end
         3'd5: begin v512 = 64'h9b05688c2b3e6c1f; v384 = 64'h8eb44a8768581511; end
         3'd6: begin v512 = 64'h1f83d9abfb41bd6b; v384 = 64'hdb0c2e0d64f98fa7; end
         default: begin v512 = 64'h5be0cd19137e2179; v384 = 64'h47b5481dbefa4fa4; end
      endcase
      return trunc ? v384[WordSize-1:0] : v512[63 -: WordSize];
   endfunction

   state_e                 state;
   logic [6:0]             cnt;
   logic                   busy_q;
   logic                   mode_q;
   logic                   last_q;
   logic [DigestWidth-1:0] digest_q;
   logic                   digest_valid_q;
   word_t                  hv  [8];
   word_t                  wv  [8];
   word_t                  win [16];

   word_t                  t1;
   word_t                  t2;
   word_t                  w_new;
   logic [DigestWidth-1:0] h_sum;

   // win[j] holds W[t+j] during round t, so the schedule is a plain shift register.
   always_comb begin
      t1 = wv[7] + big_sigma1(wv[4]) + ((wv[4] & wv[5]) ^ (~wv[4] & wv[6]))
         + k_word(cnt) + win[0];
      t2 = big_sigma0(wv[0]) + ((wv[0] & wv[1]) ^ (wv[0] & wv[2]) ^ (wv[1] & wv[2]));
      w_new = small_sigma1(win[14]) + win[9] + small_sigma0(win[1]) + win[0];
      h_sum = '0;
      for (int i = 0; i < 8; i++) begin
         h_sum[DigestWidth-1-i*WordSize -: WordSize] = hv[i] + wv[i];
      end
   end

   // NOTE: every register below is assigned with <= so all state updates see the
   // pre-edge values; blocking assignments here would chain a..h within one edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state          <= ST_IDLE;
         cnt            <= '0;
         busy_q         <= 1'b0;
         mode_q         <= 1'b0;
         last_q         <= 1'b0;
         digest_q       <= '0;
         digest_valid_q <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            hv[i] <= '0;
            wv[i] <= '0;
         end
         // NOTE: the schedule window is only 16 words of flops, so it is reset along
         // with everything else rather than left to power up undefined.
         for (int j = 0; j < 16; j++) begin
            win[j] <= '0;
         end
      end else if (abort_i) begin
         state          <= ST_IDLE;
         cnt            <= '0;
         busy_q         <= 1'b0;
         digest_q       <= '0;
         digest_valid_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_WAIT, ST_DONE: begin
               if (block_valid_i) begin
                  if (state == ST_WAIT) begin
                     for (int i = 0; i < 8; i++) wv[i] <= hv[i];
                  end else begin
                     mode_q         <= mode_i;
                     digest_valid_q <= 1'b0;
                     for (int i = 0; i < 8; i++) begin
                        hv[i] <= iv_word(3'(i), mode_i);
                        wv[i] <= iv_word(3'(i), mode_i);
                     end
                  end
                  for (int j = 0; j < 16; j++) begin
                     win[j] <= block_i[BlockWidth-1-j*WordSize -: WordSize];
                  end
                  last_q <= last_i;
                  cnt    <= '0;
                  busy_q <= 1'b1;
                  state  <= ST_HASH;
               end
            end
            ST_HASH: begin
               wv[7] <= wv[6];
               wv[6] <= wv[5];
               wv[5] <= wv[4];
               wv[4] <= wv[3] + t1;
               wv[3] <= wv[2];
               wv[2] <= wv[1];
               wv[1] <= wv[0];
               wv[0] <= t1 + t2;
               for (int j = 0; j < 15; j++) win[j] <= win[j+1];
               win[15] <= w_new;
               if (cnt == 7'(NumRounds - 1)) begin
                  cnt   <= '0;
                  state <= ST_FINAL;
               end else begin
                  cnt <= cnt + 7'd1;
               end
            end
            ST_FINAL: begin
               for (int i = 0; i < 8; i++) hv[i] <= hv[i] + wv[i];
               busy_q <= 1'b0;
               if (last_q) begin
                  digest_q       <= mode_q ? (h_sum & TruncMask) : h_sum;
                  digest_valid_q <= 1'b1;
                  state          <= ST_DONE;
               end else begin
                  state <= ST_WAIT;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign block_ready_o  = (state == ST_IDLE || state == ST_WAIT || state == ST_DONE) & ~abort_i;
   assign busy_o         = busy_q;
   assign digest_o       = digest_q;
   assign digest_valid_o = digest_valid_q;

endmodule

// File: tb/tb_sha2_core.sv
// Directed bench for sha2_core: one 32-bit and one 64-bit instance checked against
// published FIPS 180-4 example digests, plus handshake, abort and reset behaviour.
module tb_sha2_core;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [511:0]  blk_s;
   logic          v_s, l_s, m_s, a_s;
   logic          rdy_s, busy_s, dv_s;
   logic [255:0]  dg_s;

   logic [1023:0] blk_l;
   logic          v_l, l_l, m_l, a_l;
   logic          rdy_l, busy_l, dv_l;
   logic [511:0]  dg_l;

   int num_checks = 0;
   int num_fail   = 0;

   sha2_core #(.WordSize(32)) u_sha256 (
      .clk_i(clk), .rst_ni(rst_n), .block_i(blk_s), .block_valid_i(v_s),
      .block_ready_o(rdy_s), .last_i(l_s), .mode_i(m_s), .abort_i(a_s),
      .busy_o(busy_s), .digest_o(dg_s), .digest_valid_o(dv_s));

   sha2_core #(.WordSize(64)) u_sha512 (
      .clk_i(clk), .rst_ni(rst_n), .block_i(blk_l), .block_valid_i(v_l),
      .block_ready_o(rdy_l), .last_i(l_l), .mode_i(m_l), .abort_i(a_l),
      .busy_o(busy_l), .digest_o(dg_l), .digest_valid_o(dv_l));

   localparam logic [511:0] AbcBlk32 = {32'h61626380, {14{32'h0}}, 32'h00000018};
   localparam logic [1023:0] AbcBlk64 = {64'h6162638000000000, {14{64'h0}}, 64'h18};
   localparam logic [511:0] TwoBlk1 = {
      32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768,
      32'h66676869, 32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d,
      32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h0};
   localparam logic [511:0] TwoBlk2 = {{15{32'h0}}, 32'h000001c0};

   localparam logic [255:0] Sha256Abc =
      256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] Sha224Abc =
      256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000;
   localparam logic [255:0] Sha256Two =
      256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
   localparam logic [511:0] Sha512Abc = {
      256'hddaf35a193617abacc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a,
      256'h2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f};
   localparam logic [511:0] Sha384Abc = {
      256'hcb00753f45a35e8bb5a03d699ac65007272c32ab0eded1631a8b605a43ff5bed,
      128'h8086072ba1e7cc2358baeca134c825a7, 128'h0};

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      num_checks++;
      if (got !== exp) begin
         num_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic obs_busy(input bit is64);  return is64 ? busy_l : busy_s; endfunction
   function automatic logic obs_ready(input bit is64); return is64 ? rdy_l : rdy_s;   endfunction
   function automatic logic obs_dv(input bit is64);    return is64 ? dv_l : dv_s;     endfunction
   function automatic logic [511:0] obs_digest(input bit is64);
      return is64 ? dg_l : {256'h0, dg_s};
   endfunction

   // Offers a block and returns #1 after the edge that accepted it.
   task automatic send(input bit is64, input logic [1023:0] blk, input bit last, input bit mode);
      int n = 0;
      if (is64) begin
         blk_l = blk; l_l = last; m_l = mode; v_l = 1'b1;
      end else begin
         blk_s = blk[511:0]; l_s = last; m_s = mode; v_s = 1'b1;
      end
      while (!obs_ready(is64) && n < 200) begin
         @(posedge clk); #1; n++;
      end
      check("send ready within bound", 512'(n < 200), 512'(1));
      @(posedge clk); #1;
      v_s = 1'b0;
      v_l = 1'b0;
   endtask

   // Acceptance happens in cycle 0; ready/valid return in cycle NumRounds+2.
   task automatic wait_block(input bit is64, input string tag);
      int n = 0;
      check({tag, " busy after accept"}, 512'(obs_busy(is64)), 512'(1));
      check({tag, " ready low in hash"}, 512'(obs_ready(is64)), 512'(0));
      check({tag, " valid low after accept"}, 512'(obs_dv(is64)), 512'(0));
      while (obs_busy(is64) && n < 300) begin
         @(posedge clk); #1; n++;
      end
      check({tag, " cycles to completion"}, 512'(n + 1), 512'(is64 ? 82 : 66));
   endtask

   initial begin
      rst_n = 1'b1;
      {v_s, l_s, m_s, a_s, v_l, l_l, m_l, a_l} = '0;
      blk_s = '0;
      blk_l = '0;
      #2 rst_n = 1'b0;
      #10;
      check("reset busy32", 512'(busy_s), 512'(0));
      check("reset ready32", 512'(rdy_s), 512'(1));
      check("reset valid32", 512'(dv_s), 512'(0));
      check("reset digest32", obs_digest(0), 512'(0));
      check("reset busy64", 512'(busy_l), 512'(0));
      check("reset ready64", 512'(rdy_l), 512'(1));
      check("reset digest64", obs_digest(1), 512'(0));
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;

      send(0, AbcBlk32, 1, 0);
      wait_block(0, "sha256 abc");
      check("sha256 abc valid", 512'(dv_s), 512'(1));
      check("sha256 abc digest", obs_digest(0), {256'h0, Sha256Abc});
      check("done ready", 512'(rdy_s), 512'(1));

      send(0, AbcBlk32, 1, 1);
      wait_block(0, "sha224 abc");
      check("sha224 abc valid", 512'(dv_s), 512'(1));
      check("sha224 abc digest", obs_digest(0), {256'h0, Sha224Abc});

      send(0, TwoBlk1, 0, 0);
      wait_block(0, "two-block b1");
      check("wait no valid", 512'(dv_s), 512'(0));
      check("wait ready", 512'(rdy_s), 512'(1));
      repeat (5) @(posedge clk);
      #1;
      check("wait holds", 512'(busy_s), 512'(0));
      send(0, TwoBlk2, 1, 1);
      wait_block(0, "two-block b2");
      check("two-block valid", 512'(dv_s), 512'(1));
      check("two-block digest", obs_digest(0), {256'h0, Sha256Two});

      send(1, AbcBlk64, 1, 0);
      wait_block(1, "sha512 abc");
      check("sha512 abc valid", 512'(dv_l), 512'(1));
      check("sha512 abc digest", obs_digest(1), Sha512Abc);
      send(1, AbcBlk64, 1, 1);
      wait_block(1, "sha384 abc");
      check("sha384 abc digest", obs_digest(1), Sha384Abc);

      // Abort at round 30 with a block offered at the same time.
      send(0, AbcBlk32, 1, 0);
      repeat (30) @(posedge clk);
      #1;
      blk_s = TwoBlk1; l_s = 1'b1; m_s = 1'b0; v_s = 1'b1; a_s = 1'b1;
      #1;
      check("abort blocks ready", 512'(rdy_s), 512'(0));
      @(posedge clk); #1;
      a_s = 1'b0;
      v_s = 1'b0;
      #1;
      check("abort idle busy", 512'(busy_s), 512'(0));
      check("abort valid", 512'(dv_s), 512'(0));
      check("abort digest", obs_digest(0), 512'(0));
      check("abort ready", 512'(rdy_s), 512'(1));
      @(posedge clk); #1;
      check("abort no accept", 512'(busy_s), 512'(0));
      send(0, AbcBlk32, 1, 0);
      wait_block(0, "post-abort abc");
      check("post-abort digest", obs_digest(0), {256'h0, Sha256Abc});

      // Asynchronous reset in the middle of HASH.
      send(0, AbcBlk32, 1, 0);
      repeat (10) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("rst busy", 512'(busy_s), 512'(0));
      check("rst ready", 512'(rdy_s), 512'(1));
      check("rst valid", 512'(dv_s), 512'(0));
      check("rst digest", obs_digest(0), 512'(0));
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      send(0, AbcBlk32, 1, 0);
      wait_block(0, "post-reset abc");
      check("post-reset digest", obs_digest(0), {256'h0, Sha256Abc});

      $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
      $finish;
   end

endmodule
